video_out_dma_reader: RTL and testbench
=======================================

Name: video_out_dma_reader

Overview:
- Avalon-MM read master that fetches a 16-bit pixel frame buffer from SDRAM.
- Emits the pixels as an Avalon-ST video stream with startofpacket/endofpacket framing.
- Mirror of the video-in DMA writer: the CPU programs buffer/back-buffer addresses through a 4-register control slave, and front/back swaps occur only at frame boundaries.
- Sits between the SDRAM interconnect and the downstream scaler / VGA pipeline.

Parameters:
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- FIFO_DEPTH, 16, pixel FIFO entries (power of 2, ≥4)
- BUF_DEFAULT, 32'h0000_0000, reset value of front buffer register
- BACK_DEFAULT, 32'h0002_5800, reset value of back buffer register

Ports:
- sys_clk_clk  in  1  system clock
- sys_reset_reset_n  in  1  async active-low reset
- ctrl_address  in  2  control register select
- ctrl_byteenable  in  4  write byte lanes
- ctrl_read  in  1  register read strobe
- ctrl_write  in  1  register write strobe
- ctrl_writedata  in  32  write data
- ctrl_readdata  out  32  read data, 1-cycle latency
- dma_master_address  out  32  byte address
- dma_master_read  out  1  read request
- dma_master_waitrequest  in  1  slave stall
- dma_master_readdata  in  16  returned pixel
- dma_master_readdatavalid  in  1  returned pixel valid
- stream_data  out  16  RGB565 pixel
- stream_startofpacket  out  1  first pixel of frame
- stream_endofpacket  out  1  last pixel of frame
- stream_valid  out  1  pixel available
- stream_ready  in  1  downstream accept

Behaviour:
- Reset: async on sys_reset_reset_n low. All outputs are 0 at reset.
  - buffer=BUF_DEFAULT, backbuffer=BACK_DEFAULT, enable=0, swap_pending=0.
  - FIFO empty, outstanding=0, state IDLE.
- Registers (ctrl_readdata registered, valid the cycle after ctrl_read):
  - 0 buffer: RO. Any write sets swap_pending; data is ignored.
  - 1 backbuffer: RW, byteenable-masked.
  - 2 resolution: RO, {HEIGHT[15:0],WIDTH[15:0]}.
  - 3 status: bit0 swap_pending (RO), bit2 enable (RW via byteenable[0]). Other bits read 0.
- FSM IDLE / FETCH / FLUSH:
  - IDLE: on enable=1 and FIFO empty, latch frame_base=buffer, rd_idx=0 -> FETCH.
  - FETCH: dma_master_address = frame_base + 2*rd_idx.
    - Assert dma_master_read only when fifo_count + outstanding < FIFO_DEPTH.
    - Address and read stay stable while waitrequest=1.
    - A request is accepted when read & !waitrequest: rd_idx++, outstanding++.
    - When the accepted index is WIDTH*HEIGHT-1 -> FLUSH.
  - FLUSH: one cycle; perform swap if pending. Then:
    - enable=1: latch frame_base=buffer (post-swap value), rd_idx=0, next FETCH.
    - enable=0: IDLE.
- Swap: buffer<=backbuffer, backbuffer<=old buffer, swap_pending<=0.
  - A reg0 write in the same cycle as a swap leaves swap_pending=1.
  - A reg1 write in the same cycle as a swap is dropped; the swap wins.
- readdatavalid pushes readdata into the FIFO and decrements outstanding. An accept and a return in the same cycle leave outstanding unchanged. Overflow is impossible by construction; the bench asserts it never occurs.
- Stream:
  - stream_valid = FIFO non-empty; data is the FIFO head.
  - A pop occurs on valid & ready.
  - Output counter out_idx (0..WIDTH*HEIGHT-1) wraps on the EOP pop.
  - stream_startofpacket = (out_idx==0); stream_endofpacket = (out_idx==WIDTH*HEIGHT-1).
  - valid holds and data is stable until ready.
- Clearing enable mid-frame completes the current frame (all reads and pixels), then IDLE.
- Throughput: 1 pixel/cycle sustained when waitrequest=0 and ready=1. First-pixel latency = slave read latency + 1.

Decomposition:
- Package video_dma_pkg:
  - register address constants (REG_BUFFER=0, REG_BACK=1, REG_RES=2, REG_STATUS=3)
  - status bit indices
  - FSM state enum
  - pixel type (16-bit RGB565)
- Sub-module: video_dma_pixel_fifo, a synchronous show-ahead FIFO (DATA_W, DEPTH) with count output.

Test Plan:
- Params WIDTH=4, HEIGHT=2, zero-wait slave returning data = address[15:0]: enable=1 -> reads 0x0..0xE in order; stream emits 0x0000..0x000E; SOP on 0x0000, EOP on 0x000E; next frame restarts at 0x0.
- Write reg1=0x1000, write reg0 mid-frame -> status bit0=1; the current frame finishes from 0x0; the next frame reads 0x1000..0x100E; reg0 reads 0x1000, reg1 reads 0x0; bit0=0.
- Hold stream_ready=0 -> read stops once fifo_count+outstanding=16; no FIFO overflow; releasing ready drains in order without loss or duplication.
- waitrequest=1 for 5 cycles on 3rd read -> address 0x4 held stable with read=1; no index skip; stream data is unchanged.
- Clear enable at pixel 3 -> frame completes through EOP, then no further reads; reg3 reads 0x0. Assert reset mid-frame -> all outputs 0 immediately and registers return to defaults.
- Read reg2 -> 0x0002_0004 one cycle after ctrl_read. Write reg1 with byteenable=4'b0011, data 0xFFFF_FFFF, from 0x0002_5800 -> reg1 reads 0x0002_FFFF.

Source files
------------

// File: rtl/video_dma_pkg.sv
// video_dma_pkg: register map, status bits, FSM states and pixel type
// shared by the video-out DMA reader and its pixel FIFO.
package video_dma_pkg;
    localparam logic [1:0] REG_BUFFER = 2'd0;
    localparam logic [1:0] REG_BACK   = 2'd1;
    localparam logic [1:0] REG_RES    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam int STAT_SWAP   = 0;
    localparam int STAT_ENABLE = 2;
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_FLUSH} state_e;
    typedef logic [15:0] pixel_t;
endpackage

// File: rtl/video_dma_pixel_fifo.sv
// video_dma_pixel_fifo: synchronous show-ahead FIFO; rdata is the head
// entry whenever empty is low, count reports the current occupancy.
module video_dma_pixel_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
endmodule

// File: rtl/video_out_dma_reader.sv
// video_out_dma_reader: Avalon-MM read master streaming a 16-bit frame buffer
// out as Avalon-ST video, with a CPU-controlled front/back buffer swap at frame ends.
module video_out_dma_reader
    import video_dma_pkg::*;
#(
    parameter int          WIDTH        = 320,
    parameter int          HEIGHT       = 240,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] BUF_DEFAULT  = 32'h0000_0000,
    parameter logic [31:0] BACK_DEFAULT = 32'h0002_5800
) (
    input  logic        sys_clk_clk,
    input  logic        sys_reset_reset_n,
    input  logic [1:0]  ctrl_address,
    input  logic [3:0]  ctrl_byteenable,
    input  logic        ctrl_read,
    input  logic        ctrl_write,
    input  logic [31:0] ctrl_writedata,
    output logic [31:0] ctrl_readdata,
    output logic [31:0] dma_master_address,
    output logic        dma_master_read,
    input  logic        dma_master_waitrequest,
    input  logic [15:0] dma_master_readdata,
    input  logic        dma_master_readdatavalid,
    output logic [15:0] stream_data,
    output logic        stream_startofpacket,
    output logic        stream_endofpacket,
    output logic        stream_valid,
    input  logic        stream_ready
);
    localparam int N  = WIDTH * HEIGHT;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q, state_d;
    logic [31:0]   buffer_q, buffer_d, back_q, back_d, frame_base_q, frame_base_d;
    logic [31:0]   readdata_q, readdata_d, status, rd_mux;
    logic          enable_q, enable_d, swap_pending_q, swap_pending_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d, out_idx_q, out_idx_d;
    logic [CW-1:0] outstanding_q, outstanding_d, fifo_count;
    logic          fifo_empty, accept, pop, swap, wr_buf, wr_back, wr_stat;
    pixel_t        fifo_head;

    video_dma_pixel_fifo #(.DATA_W(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (sys_clk_clk),
        .rst_n (sys_reset_reset_n),
        .push  (dma_master_readdatavalid),
        .wdata (dma_master_readdata),
        .pop   (pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // Credit check counts in-flight reads so returned data always has a FIFO slot.
    assign dma_master_read    = (state_q == ST_FETCH) &&
                                (({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CW+1)'(FIFO_DEPTH));
    assign dma_master_address = frame_base_q + (32'(rd_idx_q) << 1);
    assign accept             = dma_master_read & ~dma_master_waitrequest;
    assign stream_valid       = ~fifo_empty;
    assign stream_data        = stream_valid ? fifo_head : '0;
    assign stream_startofpacket = stream_valid && (out_idx_q == '0);
    assign stream_endofpacket   = stream_valid && (out_idx_q == IW'(N-1));
    assign pop                = stream_valid & stream_ready;
    assign ctrl_readdata      = readdata_q;
    assign wr_buf             = ctrl_write && (ctrl_address == REG_BUFFER);
    assign wr_back            = ctrl_write && (ctrl_address == REG_BACK);
    assign wr_stat            = ctrl_write && (ctrl_address == REG_STATUS);
    assign swap               = (state_q == ST_FLUSH) && swap_pending_q;

    always_comb begin
        state_d      = state_q;
        frame_base_d = frame_base_q;
        rd_idx_d     = rd_idx_q;
        case (state_q)
            ST_IDLE: if (enable_q && fifo_empty) begin
                frame_base_d = buffer_q;
                rd_idx_d     = '0;
                state_d      = ST_FETCH;
            end
            ST_FETCH: if (accept) begin
                rd_idx_d = rd_idx_q + IW'(1);
                if (rd_idx_q == IW'(N-1)) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                frame_base_d = swap ? back_q : buffer_q;
                rd_idx_d     = '0;
                state_d      = enable_q ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        outstanding_d = outstanding_q + CW'(accept) - CW'(dma_master_readdatavalid);
        out_idx_d = pop ? ((out_idx_q == IW'(N-1)) ? '0 : out_idx_q + IW'(1)) : out_idx_q;
        buffer_d = swap ? back_q : buffer_q;
        back_d   = back_q;
        if (wr_back)
            for (int i = 0; i < 4; i++)
                if (ctrl_byteenable[i]) back_d[8*i +: 8] = ctrl_writedata[8*i +: 8];
        // The swap owns the back register that cycle; a concurrent CPU write is lost.
        if (swap) back_d = buffer_q;
        swap_pending_d = wr_buf | (swap_pending_q & ~swap);
        enable_d = (wr_stat && ctrl_byteenable[0]) ? ctrl_writedata[STAT_ENABLE] : enable_q;
        status = '0;
        status[STAT_SWAP]   = swap_pending_q;
        status[STAT_ENABLE] = enable_q;
        rd_mux = (ctrl_address == REG_BUFFER) ? buffer_q :
                 (ctrl_address == REG_BACK)   ? back_q :
                 (ctrl_address == REG_RES)    ? {16'(HEIGHT), 16'(WIDTH)} : status;
        readdata_d = ctrl_read ? rd_mux : readdata_q;
    end

    always_ff @(posedge sys_clk_clk or negedge sys_reset_reset_n) begin
        if (!sys_reset_reset_n) begin
            state_q        <= ST_IDLE;
            buffer_q       <= BUF_DEFAULT;
            back_q         <= BACK_DEFAULT;
            frame_base_q   <= '0;
            readdata_q     <= '0;
            enable_q       <= 1'b0;
            swap_pending_q <= 1'b0;
            rd_idx_q       <= '0;
            out_idx_q      <= '0;
            outstanding_q  <= '0;
        end else begin
            state_q        <= state_d;
            buffer_q       <= buffer_d;
            back_q         <= back_d;
            frame_base_q   <= frame_base_d;
            readdata_q     <= readdata_d;
            enable_q       <= enable_d;
            swap_pending_q <= swap_pending_d;
            rd_idx_q       <= rd_idx_d;
            out_idx_q      <= out_idx_d;
            outstanding_q  <= outstanding_d;
        end
    end
endmodule

// File: tb/tb_video_out_dma_reader.sv
// tb_video_out_dma_reader: randomized scoreboard bench for a 4x2 frame with a
// random-latency slave that returns each pixel's own byte address as data.
module tb_video_out_dma_reader;
    import video_dma_pkg::*;
    localparam int W = 4, H = 2, NPIX = W * H;

    logic        clk = 1'b0, rst_n;
    logic [1:0]  ctrl_address;
    logic [3:0]  ctrl_byteenable;
    logic        ctrl_read, ctrl_write;
    logic [31:0] ctrl_writedata, ctrl_readdata, dma_master_address;
    logic        dma_master_read, waitreq, rdv;
    logic [15:0] rdata, stream_data;
    logic        stream_startofpacket, stream_endofpacket, stream_valid, stream_ready;

    video_out_dma_reader #(.WIDTH(W), .HEIGHT(H)) dut (
        .sys_clk_clk              (clk),
        .sys_reset_reset_n        (rst_n),
        .ctrl_address             (ctrl_address),
        .ctrl_byteenable          (ctrl_byteenable),
        .ctrl_read                (ctrl_read),
        .ctrl_write               (ctrl_write),
        .ctrl_writedata           (ctrl_writedata),
        .ctrl_readdata            (ctrl_readdata),
        .dma_master_address       (dma_master_address),
        .dma_master_read          (dma_master_read),
        .dma_master_waitrequest   (waitreq),
        .dma_master_readdata      (rdata),
        .dma_master_readdatavalid (rdv),
        .stream_data              (stream_data),
        .stream_startofpacket     (stream_startofpacket),
        .stream_endofpacket       (stream_endofpacket),
        .stream_valid             (stream_valid),
        .stream_ready             (stream_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [15:0] d; int due; } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_addr[$], exp_reg[$];
    logic [17:0] exp_px[$];
    string       exp_reg_name[$], chk_name[$];
    logic [63:0] chk_got[$], chk_exp[$];
    int tests = 0, fails = 0, acc_cnt = 0, pop_cnt = 0, cyc = 0, last_due = 0;
    int rdy_mode, wait_mode, stall_left = 0;
    logic stall_armed;
    string cn;
    logic [63:0] cg, ce;
    logic [31:0] er, ea;
    logic [17:0] ep;
    pend_t pe;

    // Monitor and slave responder: runs just after each rising edge and picks
    // the slave/sink inputs the DUT will see at the next edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        while (chk_got.size() > 0) begin
            cn = chk_name.pop_front(); cg = chk_got.pop_front(); ce = chk_exp.pop_front();
            tests++;
            if (cg !== ce) begin fails++; $display("FAIL %s: got %0h expected %0h", cn, cg, ce); end
        end
        if (!rst_n) begin
            pend.delete(); exp_px.delete(); exp_addr.delete();
            acc_cnt = 0; pop_cnt = 0; waitreq = 1'b0; rdv = 1'b0; rdata = '0; stream_ready = 1'b0;
        end else begin
            if (ctrl_read) begin
                tests++;
                if (exp_reg.size() == 0) begin fails++; $display("FAIL reg_unexpected: got %0h expected none", ctrl_readdata); end
                else begin
                    er = exp_reg.pop_front(); cn = exp_reg_name.pop_front();
                    if (ctrl_readdata !== er) begin fails++; $display("FAIL %s: got %0h expected %0h", cn, ctrl_readdata, er); end
                end
            end
            stream_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 9) < 7);
            if (stall_left > 0) begin
                tests++;
                if (!(dma_master_read && dma_master_address == 32'h4)) begin
                    fails++; $display("FAIL stall_hold: got read=%0b addr=%0h expected read=1 addr=4", dma_master_read, dma_master_address);
                end
                stall_left--; waitreq = 1'b1;
            end else if (stall_armed && dma_master_read && dma_master_address == 32'h4) begin
                stall_armed = 1'b0; stall_left = 4; waitreq = 1'b1;
            end else waitreq = (wait_mode == 1) && ($urandom_range(0, 3) == 0);
            if (dma_master_read && !waitreq) begin
                acc_cnt++;
                tests++;
                if (exp_addr.size() == 0) begin fails++; $display("FAIL read_addr: got %0h expected no read", dma_master_address); end
                else begin
                    ea = exp_addr.pop_front();
                    if (dma_master_address !== ea) begin fails++; $display("FAIL read_addr: got %0h expected %0h", dma_master_address, ea); end
                end
                tests++;
                if (acc_cnt - pop_cnt > 16) begin fails++; $display("FAIL fifo_overflow: got %0d in flight expected <= 16", acc_cnt - pop_cnt); end
                pe.d = dma_master_address[15:0];
                pe.due = cyc + $urandom_range(1, 3);
                if (pe.due <= last_due) pe.due = last_due + 1;
                last_due = pe.due;
                pend.push_back(pe);
            end
            if (stream_valid && stream_ready) begin
                pop_cnt++;
                tests++;
                if (exp_px.size() == 0) begin fails++; $display("FAIL pixel: got %0h expected none", stream_data); end
                else begin
                    ep = exp_px.pop_front();
                    if ({stream_data, stream_startofpacket, stream_endofpacket} !== ep)
                        begin fails++; $display("FAIL pixel: got %0h sop=%0b eop=%0b expected %0h sop=%0b eop=%0b",
                                       stream_data, stream_startofpacket, stream_endofpacket, ep[17:2], ep[1], ep[0]); end
                end
            end
            rdv = 1'b0; rdata = '0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin pe = pend.pop_front(); rdv = 1'b1; rdata = pe.d; end
        end
    end

    task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
        chk_name.push_back(n); chk_got.push_back(g); chk_exp.push_back(e);
    endtask

    task automatic push_frame(input logic [31:0] base);
        for (int i = 0; i < NPIX; i++) begin
            exp_addr.push_back(base + 32'(2 * i));
            exp_px.push_back({16'(base + 32'(2 * i)), i == 0, i == NPIX - 1});
        end
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        ctrl_address = a; ctrl_byteenable = be; ctrl_writedata = d; ctrl_write = 1'b1;
        @(negedge clk);
        ctrl_write = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, input logic [31:0] e, input string n);
        @(negedge clk);
        exp_reg.push_back(e); exp_reg_name.push_back(n);
        ctrl_address = a; ctrl_read = 1'b1;
        @(negedge clk);
        ctrl_read = 1'b0;
    endtask

    task automatic wait_acc(input int n, input string nm);
        int k = 0;
        while (acc_cnt < n && k < 3000) begin @(negedge clk); k++; end
        chk(nm, 64'(acc_cnt >= n), 64'(1));
    endtask

    task automatic wait_pop(input int n, input string nm);
        int k = 0;
        while (pop_cnt < n && k < 3000) begin @(negedge clk); k++; end
        chk(nm, 64'(pop_cnt >= n), 64'(1));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_stream"}, 64'({stream_valid, stream_startofpacket, stream_endofpacket, stream_data}), 64'(0));
        chk({tag, "_master"}, 64'({dma_master_read, dma_master_address}), 64'(0));
        chk({tag, "_rdata"}, 64'(ctrl_readdata), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0; ctrl_address = '0; ctrl_byteenable = '0; ctrl_read = 1'b0;
        ctrl_write = 1'b0; ctrl_writedata = '0; rdy_mode = 1; wait_mode = 0; stall_armed = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("rst");
        rst_n = 1'b1;
        reg_rd(REG_BUFFER, 32'h0, "reg0_default");
        reg_rd(REG_BACK, 32'h0002_5800, "reg1_default");
        reg_rd(REG_RES, 32'h0002_0004, "reg2_res");
        reg_rd(REG_STATUS, 32'h0, "reg3_default");
        reg_wr(REG_BACK, 4'b0011, 32'hFFFF_FFFF);
        reg_rd(REG_BACK, 32'h0002_FFFF, "reg1_byteenable");
        reg_wr(REG_BACK, 4'hF, 32'h1000);
        // Frames 0-1 from the front buffer; the swap requested in frame 1 redirects frames 2-6.
        push_frame(32'h0); push_frame(32'h0);
        for (int f = 0; f < 5; f++) push_frame(32'h1000);
        stall_armed = 1'b1;
        reg_wr(REG_STATUS, 4'b0001, 32'h4);
        wait_acc(9, "wait_frame1");
        reg_wr(REG_BUFFER, 4'hF, 32'hDEAD_BEEF);
        reg_rd(REG_STATUS, 32'h5, "reg3_pending");
        wait_mode = 1; rdy_mode = 2;
        wait_acc(18, "wait_frame2");
        reg_rd(REG_BUFFER, 32'h1000, "reg0_swapped");
        reg_rd(REG_BACK, 32'h0, "reg1_swapped");
        reg_rd(REG_STATUS, 32'h4, "reg3_swapped");
        chk("stall_seen", 64'(stall_armed), 64'(0));
        wait_acc(26, "wait_frame3");
        rdy_mode = 0;
        repeat (40) @(negedge clk);
        chk("inflight_cap", 64'(acc_cnt - pop_cnt), 64'(16));
        chk("read_blocked", 64'(dma_master_read), 64'(0));
        rdy_mode = 2;
        wait_acc(51, "wait_frame6");
        reg_wr(REG_STATUS, 4'b0001, 32'h0);
        wait_pop(56, "drain_frame6");
        repeat (20) @(negedge clk);
        chk("acc_total", 64'(acc_cnt), 64'(56));
        chk("idle_no_read", 64'(dma_master_read), 64'(0));
        chk("px_left", 64'(exp_px.size()), 64'(0));
        reg_rd(REG_STATUS, 32'h0, "reg3_idle");
        push_frame(32'h1000);
        rdy_mode = 1; wait_mode = 0;
        reg_wr(REG_STATUS, 4'b0001, 32'h4);
        wait_acc(59, "wait_reset_frame");
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 chk_zero_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        reg_rd(REG_BUFFER, 32'h0, "reg0_after_reset");
        reg_rd(REG_BACK, 32'h0002_5800, "reg1_after_reset");
        reg_rd(REG_STATUS, 32'h0, "reg3_after_reset");
        push_frame(32'h0);
        rdy_mode = 2; wait_mode = 1;
        reg_wr(REG_STATUS, 4'b0001, 32'h4);
        wait_acc(3, "wait_last_frame");
        reg_wr(REG_STATUS, 4'b0001, 32'h0);
        wait_pop(8, "drain_last_frame");
        repeat (10) @(negedge clk);
        chk("acc_last", 64'(acc_cnt), 64'(8));
        chk("addr_left", 64'(exp_addr.size()), 64'(0));
        chk("px_left_last", 64'(exp_px.size()), 64'(0));
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
